vec_mem_responder: RTL

Memory-side responder for the 128-bit vector load/store port of the pipelined SIMD core. Accepts one vector request at a time: a store carries the `data_b` vector register value, a load returns the `q_b` vector. Each transfer is split into four 32-bit beats against a word-wide synchronous sample RAM. Exposes `ready`/`stall` to the hazard unit and a one-cycle `done` strobe per completed transfer.

---
 rtl/vec_mem_responder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/vec_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : vec_mem_responder
// Purpose  : Memory-side responder for a 128-bit vector load/store port.
//            One vector request is accepted at a time. Each transfer is
//            split into four 32-bit beats against a word-wide synchronous
//            RAM. Loads are collected in a staging buffer and published to
//            q_b_o only when the whole vector has returned.
// Ports    :
//   clk_i        clock, all state updates on the rising edge
//   reset_i      synchronous active-high reset
//   req_i        single-cycle request strobe (accepted while ready_o = 1)
//   we_i         1 = store, 0 = load (sampled with req_i)
//   vaddr_i      vector byte address (bits [3:0] expected zero)
//   data_b_i     store data (sampled with req_i)
//   q_b_o        last completed load result
//   ready_o      responder idle
//   stall_o      req_i | ~ready_o, holds the pipeline
//   done_o       one-cycle pulse on the last cycle of a transfer
//   misalign_o   sticky: an accepted request had vaddr_i[3:0] != 0
//   overrun_o    sticky: req_i seen while busy
//   ram_addr_o   RAM word address
//   ram_we_o     RAM write enable
//   ram_wdata_o  RAM write data
//   ram_rdata_i  RAM read data, valid RD_LAT cycles after the address
// Revision : 1.0 - initial release
// ============================================================================
module vec_mem_responder #(
   parameter int AW     = 10,
   parameter int RD_LAT = 1
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          req_i,
   input  logic          we_i,
   input  logic [31:0]   vaddr_i,
   input  logic [127:0]  data_b_i,
   output logic [127:0]  q_b_o,
   output logic          ready_o,
   output logic          stall_o,
   output logic          done_o,
   output logic          misalign_o,
   output logic          overrun_o,
   output logic [AW-1:0] ram_addr_o,
   output logic          ram_we_o,
   output logic [31:0]   ram_wdata_o,
   input  logic [31:0]   ram_rdata_i
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WR       = 2'd1,
      S_RD_ISSUE = 2'd2,
      S_RD_DRAIN = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      beat_q, beat_d;
   logic [AW-3:0]   base_q, base_d;
   logic [127:0]    wdata_q, wdata_d;
   logic [127:0]    stage_q, stage_d;
   logic [127:0]    q_b_q, q_b_d;
   logic            misalign_q, misalign_d;
   logic            overrun_q, overrun_d;

   // Read-return tracking: one valid bit and beat index per cycle of RAM latency.
   logic [RD_LAT-1:0] lat_vld_q;
   logic [1:0]        lat_idx_q [RD_LAT];
   logic              w_issue;

   // Address bits above the RAM are dropped on purpose (slot wrap by truncation).
   logic w_unused;
   assign w_unused = ^vaddr_i[31:AW+2];

   assign ready_o    = (state_q == S_IDLE);
   assign stall_o    = req_i | ~ready_o;
   assign q_b_o      = q_b_q;
   assign misalign_o = misalign_q;
   assign overrun_o  = overrun_q;

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      stage_d     = stage_q;
      q_b_d       = q_b_q;
      misalign_d  = misalign_q;
      overrun_d   = overrun_q;
      done_o      = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      w_issue     = 1'b0;

      // Returning read data lands in its beat slot; done before the state
      // case so the drain state can publish the beat captured this cycle.
      if (lat_vld_q[RD_LAT-1]) begin
         stage_d[{lat_idx_q[RD_LAT-1], 5'd0} +: 32] = ram_rdata_i;
      end

      if (req_i && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               base_d  = vaddr_i[AW+1:4];
               wdata_d = data_b_i;
               beat_d  = 2'd0;
               if (vaddr_i[3:0] != 4'd0) begin
                  misalign_d = 1'b1;
               end
               state_d = we_i ? S_WR : S_RD_ISSUE;
            end
         end
         S_WR: begin
            ram_we_o    = 1'b1;
            ram_addr_o  = {base_q, beat_q};
            ram_wdata_o = wdata_q[{beat_q, 5'd0} +: 32];
            beat_d      = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
               done_o  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_RD_ISSUE: begin
            ram_addr_o = {base_q, beat_q};
            w_issue    = 1'b1;
            beat_d     = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
               state_d = S_RD_DRAIN;
            end
         end
         S_RD_DRAIN: begin
            // Beats return in issue order, so beat 3 arriving means the
            // whole vector is in the staging buffer.
            if (lat_vld_q[RD_LAT-1] && (lat_idx_q[RD_LAT-1] == 2'd3)) begin
               done_o  = 1'b1;
               q_b_d   = stage_d;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         beat_q     <= 2'd0;
         base_q     <= '0;
         wdata_q    <= '0;
         stage_q    <= '0;
         q_b_q      <= '0;
         misalign_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         base_q     <= base_d;
         wdata_q    <= wdata_d;
         stage_q    <= stage_d;
         q_b_q      <= q_b_d;
         misalign_q <= misalign_d;
         overrun_q  <= overrun_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lat_vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            lat_idx_q[i] <= 2'd0;
         end
      end else begin
         lat_vld_q[0] <= w_issue;
         lat_idx_q[0] <= beat_q;
         for (int i = 1; i < RD_LAT; i++) begin
            lat_vld_q[i] <= lat_vld_q[i-1];
            lat_idx_q[i] <= lat_idx_q[i-1];
         end
      end
   end

endmodule
`default_nettype wire
